// File: rtl/movimento_bola.sv
// rtl/movimento_bola.sv - Pong ball position, wall/paddle bounce and score pulse engine
module movimento_bola #(
   parameter int LARGURA     = 640,
   parameter int ALTURA      = 480,
   parameter int TAM_BOLA    = 8,
   parameter int VEL         = 4,
   parameter int X_RAQ_ESQ   = 16,
   parameter int X_RAQ_DIR   = 616,
   parameter int LARG_RAQ    = 8,
   parameter int ALT_RAQUETE = 64,
   parameter int WX          = $clog2(LARGURA),
   parameter int WY          = $clog2(ALTURA)
) (
   input  logic          clock,
   input  logic          zera,
   input  logic          tick,
   input  logic          saque,
   input  logic [WY-1:0] raq_esq_y,
   input  logic [WY-1:0] raq_dir_y,
   output logic [WX-1:0] bola_x,
   output logic [WY-1:0] bola_y,
   output logic          em_jogo,
   output logic          ponto_esq,
   output logic          ponto_dir
);

   // One guard bit above the coordinate width so x+VEL / y+VEL never wraps.
   localparam int XW = WX + 1;
   localparam int YW = WY + 1;

   localparam logic [XW-1:0] X_LIM = XW'(LARGURA - TAM_BOLA);
   localparam logic [XW-1:0] X_CEN = XW'((LARGURA - TAM_BOLA) / 2);
   localparam logic [XW-1:0] FACE_D = XW'(X_RAQ_DIR - TAM_BOLA);
   localparam logic [XW-1:0] FACE_E = XW'(X_RAQ_ESQ + LARG_RAQ);
   localparam logic [XW-1:0] VEL_X = XW'(VEL);
   localparam logic [YW-1:0] Y_LIM = YW'(ALTURA - TAM_BOLA);
   localparam logic [YW-1:0] Y_CEN = YW'((ALTURA - TAM_BOLA) / 2);
   localparam logic [YW-1:0] VEL_Y = YW'(VEL);
   localparam logic [YW-1:0] TAM_Y = YW'(TAM_BOLA);
   localparam logic [YW-1:0] ALT_R = YW'(ALT_RAQUETE);

   typedef enum logic [1:0] {
      PARADO  = 2'd0,
      JOGANDO = 2'd1,
      PONTO   = 2'd2
   } estado_t;

   estado_t       estado, estado_prox;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          dir_x_q, dir_x_d;   // 1 = moving right
   logic          dir_y_q, dir_y_d;   // 1 = moving down
   logic          ponto_esq_q, ponto_esq_d;
   logic          ponto_dir_q, ponto_dir_d;

   logic [XW-1:0] x_soma, x_sub;
   logic [YW-1:0] y_soma, y_sub;
   logic [YW-1:0] raq_esq_ext, raq_dir_ext;
   logic          sobre_esq, sobre_dir;

   // State, position, direction and score pulses; zera overrides everything
   always_ff @(posedge clock) begin
      if (zera) begin
         estado      <= PARADO;
         x_q         <= X_CEN;
         y_q         <= Y_CEN;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         ponto_esq_q <= 1'b0;
         ponto_dir_q <= 1'b0;
      end else begin
         estado      <= estado_prox;
         x_q         <= x_d;
         y_q         <= y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         ponto_esq_q <= ponto_esq_d;
         ponto_dir_q <= ponto_dir_d;
      end
   end

   // Next state and next position; paddle overlap uses the pre-update y
   always_comb begin
      estado_prox = estado;
      x_d         = x_q;
      y_d         = y_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      ponto_esq_d = 1'b0;
      ponto_dir_d = 1'b0;

      x_soma      = x_q + VEL_X;
      x_sub       = x_q - VEL_X;
      y_soma      = y_q + VEL_Y;
      y_sub       = y_q - VEL_Y;
      raq_esq_ext = {1'b0, raq_esq_y};
      raq_dir_ext = {1'b0, raq_dir_y};
      sobre_esq   = ((y_q + TAM_Y) > raq_esq_ext) && (y_q < (raq_esq_ext + ALT_R));
      sobre_dir   = ((y_q + TAM_Y) > raq_dir_ext) && (y_q < (raq_dir_ext + ALT_R));

      case (estado)
         PARADO: begin
            if (saque) begin
               estado_prox = JOGANDO;
            end
         end
         JOGANDO: begin
            if (tick) begin
               if (dir_y_q) begin
                  if (y_soma >= Y_LIM) begin
                     y_d     = Y_LIM;
                     dir_y_d = 1'b0;
                  end else begin
                     y_d = y_soma;
                  end
               end else begin
                  if (y_q < VEL_Y) begin
                     y_d     = '0;
                     dir_y_d = 1'b1;
                  end else begin
                     y_d = y_sub;
                  end
               end

               if (dir_x_q) begin
                  if ((x_q < FACE_D) && (x_soma >= FACE_D) && sobre_dir) begin
                     x_d     = FACE_D;
                     dir_x_d = 1'b0;
                  end else if (x_soma > X_LIM) begin
                     x_d         = X_LIM;
                     ponto_esq_d = 1'b1;
                     estado_prox = PONTO;
                  end else begin
                     x_d = x_soma;
                  end
               end else begin
                  if ((x_q > FACE_E) && (x_sub <= FACE_E) && sobre_esq) begin
                     x_d     = FACE_E;
                     dir_x_d = 1'b1;
                  end else if (x_q < VEL_X) begin
                     x_d         = '0;
                     ponto_dir_d = 1'b1;
                     estado_prox = PONTO;
                  end else begin
                     x_d = x_sub;
                  end
               end
            end
         end
         PONTO: begin
            // Direction is kept so the next serve heads toward the conceding side
            x_d         = X_CEN;
            y_d         = Y_CEN;
            estado_prox = PARADO;
         end
         default: begin
            estado_prox = PARADO;
            x_d         = X_CEN;
            y_d         = Y_CEN;
         end
      endcase
   end

   assign bola_x    = x_q[WX-1:0];
   assign bola_y    = y_q[WY-1:0];
   assign em_jogo   = (estado == JOGANDO);
   assign ponto_esq = ponto_esq_q;
   assign ponto_dir = ponto_dir_q;

endmodule

// File: tb/tb_movimento_bola.sv
// tb/tb_movimento_bola.sv - directed scoreboard bench for movimento_bola
module tb_movimento_bola;

   logic       clock = 1'b0;
   logic       zera = 1'b0;
   logic       tick = 1'b0;
   logic       saque = 1'b0;
   logic [8:0] raq_esq_y = 9'd400;
   logic [8:0] raq_dir_y = 9'd400;
   logic [9:0] bola_x;
   logic [8:0] bola_y;
   logic       em_jogo;
   logic       ponto_esq;
   logic       ponto_dir;

   int n_assert = 0;
   int n_fail = 0;

   typedef struct {
      string tag;
      int    x;
      int    y;
      bit    em;
      bit    pe;
      bit    pd;
   } exp_t;

   exp_t sb[$];

   movimento_bola dut (
      .clock     (clock),
      .zera      (zera),
      .tick      (tick),
      .saque     (saque),
      .raq_esq_y (raq_esq_y),
      .raq_dir_y (raq_dir_y),
      .bola_x    (bola_x),
      .bola_y    (bola_y),
      .em_jogo   (em_jogo),
      .ponto_esq (ponto_esq),
      .ponto_dir (ponto_dir)
   );

   always #5 clock = ~clock;

   task automatic check_out();
      exp_t       e;
      logic [9:0] xe;
      logic [8:0] ye;
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end
      if (sb.size() != 0) begin
         e  = sb.pop_front();
         xe = e.x[9:0];
         ye = e.y[8:0];
         n_assert++;
         assert (bola_x === xe) else begin
            n_fail++;
            $error("FAIL %s bola_x observed=%0d expected=%0d", e.tag, bola_x, xe);
         end
         n_assert++;
         assert (bola_y === ye) else begin
            n_fail++;
            $error("FAIL %s bola_y observed=%0d expected=%0d", e.tag, bola_y, ye);
         end
         n_assert++;
         assert (em_jogo === e.em) else begin
            n_fail++;
            $error("FAIL %s em_jogo observed=%b expected=%b", e.tag, em_jogo, e.em);
         end
         n_assert++;
         assert (ponto_esq === e.pe) else begin
            n_fail++;
            $error("FAIL %s ponto_esq observed=%b expected=%b", e.tag, ponto_esq, e.pe);
         end
         n_assert++;
         assert (ponto_dir === e.pd) else begin
            n_fail++;
            $error("FAIL %s ponto_dir observed=%b expected=%b", e.tag, ponto_dir, e.pd);
         end
      end
   endtask

   // Drive one cycle of stimulus, record what must appear after the edge, then compare
   task automatic cyc_exp(input bit t, input bit s, input bit z, input string tag,
                          input int x, input int y, input bit em, input bit pe, input bit pd);
      exp_t e;
      e.tag = tag; e.x = x; e.y = y; e.em = em; e.pe = pe; e.pd = pd;
      sb.push_back(e);
      tick = t; saque = s; zera = z;
      @(posedge clock);
      #1;
      tick = 1'b0; saque = 1'b0; zera = 1'b0;
      check_out();
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(posedge clock);
         #1;
         tick = 1'b0;
      end
   endtask

   initial begin
      #2;
      // Reset, then ticks while stopped must not move the ball
      cyc_exp(0, 0, 1, "reset", 316, 236, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc_exp(1, 0, 0, "parado_tick", 316, 236, 0, 0, 0);

      // Episode A: right paddle at 400 reflects, left paddle at 400 misses
      cyc_exp(0, 1, 0, "a_saque", 316, 236, 1, 0, 0);
      cyc_exp(1, 0, 0, "a_t1", 320, 240, 1, 0, 0);
      adv(57);
      cyc_exp(1, 0, 0, "a_t59_bottom", 552, 472, 1, 0, 0);
      cyc_exp(1, 0, 0, "a_t60", 556, 468, 1, 0, 0);
      adv(12);
      cyc_exp(1, 0, 0, "a_t73_raq_dir", 608, 416, 1, 0, 0);
      cyc_exp(1, 0, 0, "a_t74", 604, 412, 1, 0, 0);
      adv(102);
      cyc_exp(1, 0, 0, "a_t177_top", 192, 0, 1, 0, 0);
      cyc_exp(1, 0, 0, "a_t178_top_turn", 188, 0, 1, 0, 0);
      cyc_exp(1, 0, 0, "a_t179", 184, 4, 1, 0, 0);
      adv(45);
      cyc_exp(1, 0, 0, "a_t225_edge", 0, 188, 1, 0, 0);
      cyc_exp(1, 0, 0, "a_t226_ponto_dir", 0, 192, 0, 0, 1);
      cyc_exp(1, 0, 0, "a_pos_ponto", 316, 236, 0, 0, 0);

      // Episode C: serve goes left; left paddle reflects, then right paddle at 140
      raq_dir_y = 9'd140;
      cyc_exp(1, 1, 0, "c_saque_tick", 316, 236, 1, 0, 0);
      cyc_exp(1, 0, 0, "c_t1", 312, 240, 1, 0, 0);
      adv(71);
      cyc_exp(1, 0, 0, "c_t73_raq_esq", 24, 416, 1, 0, 0);
      cyc_exp(1, 0, 0, "c_t74", 28, 412, 1, 0, 0);
      adv(144);
      cyc_exp(1, 0, 0, "c_t219_raq_dir", 608, 164, 1, 0, 0);
      cyc_exp(1, 0, 0, "c_t220", 604, 168, 1, 0, 0);
      cyc_exp(1, 0, 1, "c_zera_tick", 316, 236, 0, 0, 0);

      // Direction restored by reset; then right paddle at 0 misses
      cyc_exp(1, 1, 0, "d_saque_tick", 316, 236, 1, 0, 0);
      cyc_exp(1, 0, 0, "d_t1", 320, 240, 1, 0, 0);
      raq_dir_y = 9'd0;
      adv(77);
      cyc_exp(1, 0, 0, "b_t79", 632, 392, 1, 0, 0);
      cyc_exp(1, 0, 0, "b_t80_ponto_esq", 632, 388, 0, 1, 0);
      cyc_exp(1, 0, 0, "b_pos_ponto", 316, 236, 0, 0, 0);
      cyc_exp(0, 1, 0, "b_saque", 316, 236, 1, 0, 0);
      cyc_exp(1, 0, 0, "b_dir_kept", 320, 232, 1, 0, 0);

      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
